// File: rtl/wfa_wavefront_compact.sv
// Wavefront compaction: realigns a diagonal-indexed offset/valid array to reduced bounds
// with a log-step barrel shift toward slot 0, then masks the slots past the new length.
module wfa_wavefront_compact #(
    parameter int MAX_WAVEFRONT_LEN = 128,
    parameter int LOG_MAX_TILE_SIZE = 10,
    parameter int DATA_WIDTH        = 8
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  start,
    input  logic [MAX_WAVEFRONT_LEN-1:0][LOG_MAX_TILE_SIZE-1:0]   OffsetIn,
    input  logic [MAX_WAVEFRONT_LEN-1:0]                          ValidIn,
    input  logic signed [DATA_WIDTH-1:0]                          Kmin,
    input  logic signed [DATA_WIDTH-1:0]                          Kmax,
    input  logic signed [DATA_WIDTH-1:0]                          KminNew,
    input  logic signed [DATA_WIDTH-1:0]                          KmaxNew,
    output logic [MAX_WAVEFRONT_LEN-1:0][LOG_MAX_TILE_SIZE-1:0]   OffsetOut,
    output logic [MAX_WAVEFRONT_LEN-1:0]                          ValidOut,
    output logic signed [DATA_WIDTH-1:0]                          KminOut,
    output logic signed [DATA_WIDTH-1:0]                          KmaxOut,
    output logic                                                  busy,
    output logic                                                  done,
    output logic                                                  err,
    output logic                                                  empty,
    output logic [2:0]                                            fsm_state
);

    localparam int LOG_N = $clog2(MAX_WAVEFRONT_LEN);
    localparam logic [LOG_N-1:0] LAST_STAGE = LOG_N[LOG_N-1:0] - 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        MASK  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t state;
    state_t next_state;

    logic [MAX_WAVEFRONT_LEN-1:0][LOG_MAX_TILE_SIZE-1:0] work_off;
    logic [MAX_WAVEFRONT_LEN-1:0]                        work_valid;
    logic [MAX_WAVEFRONT_LEN-1:0]                        masked_valid;
    logic signed [DATA_WIDTH-1:0]                        cap_kmin;
    logic signed [DATA_WIDTH-1:0]                        cap_kmax;
    logic signed [DATA_WIDTH-1:0]                        cap_kmin_new;
    logic signed [DATA_WIDTH-1:0]                        cap_kmax_new;
    logic signed [DATA_WIDTH:0]                          shift_amt;
    logic signed [DATA_WIDTH:0]                          num_new;
    logic signed [DATA_WIDTH:0]                          shift_calc;
    logic signed [DATA_WIDTH:0]                          num_calc;
    logic                                                load_err;
    logic                                                op_err;
    logic [LOG_N-1:0]                                    stage_cnt;
    logic [31:0]                                         stage_step;
    logic                                                done_set;

    // start is a level request sampled only in IDLE; while busy is high it is ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = LOAD;
            LOAD:    next_state = SHIFT;
            SHIFT:   if (stage_cnt == LAST_STAGE) next_state = MASK;
            MASK:    next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        done_set  = (state == DONE);
        fsm_state = state;
        masked_valid = '0;
        for (int j = 0; j < MAX_WAVEFRONT_LEN; j++) begin
            masked_valid[j] = work_valid[j] && (j < int'(num_new)) && !op_err;
        end
    end

    // Bound arithmetic is one bit wider than the inputs so differences never wrap.
    always_comb begin
        shift_calc = (DATA_WIDTH+1)'(cap_kmin_new) - (DATA_WIDTH+1)'(cap_kmin);
        num_calc   = (DATA_WIDTH+1)'(cap_kmax_new) - (DATA_WIDTH+1)'(cap_kmin_new)
                   + (DATA_WIDTH+1)'(1);
        load_err   = (shift_calc < 0) || (cap_kmax_new > cap_kmax) ||
                     (cap_kmin_new > cap_kmax_new);
        stage_step = 32'd1 << stage_cnt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            work_off     <= '0;
            work_valid   <= '0;
            cap_kmin     <= '0;
            cap_kmax     <= '0;
            cap_kmin_new <= '0;
            cap_kmax_new <= '0;
            shift_amt    <= '0;
            num_new      <= '0;
            op_err       <= 1'b0;
            stage_cnt    <= '0;
            OffsetOut    <= '0;
            ValidOut     <= '0;
            KminOut      <= '0;
            KmaxOut      <= '0;
            err          <= 1'b0;
            empty        <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= done_set;
            case (state)
                IDLE: begin
                    if (start) begin
                        work_off     <= OffsetIn;
                        work_valid   <= ValidIn;
                        cap_kmin     <= Kmin;
                        cap_kmax     <= Kmax;
                        cap_kmin_new <= KminNew;
                        cap_kmax_new <= KmaxNew;
                    end
                end
                LOAD: begin
                    shift_amt <= shift_calc;
                    num_new   <= num_calc;
                    op_err    <= load_err;
                    stage_cnt <= '0;
                end
                SHIFT: begin
                    // Stage s moves the array 2^s slots toward slot 0; vacated slots fill with zero.
                    if (shift_amt[stage_cnt]) begin
                        work_off   <= work_off >> (stage_step * LOG_MAX_TILE_SIZE);
                        work_valid <= work_valid >> stage_step;
                    end
                    stage_cnt <= stage_cnt + 1'b1;
                end
                MASK: begin
                    OffsetOut <= work_off;
                    ValidOut  <= masked_valid;
                    KminOut   <= op_err ? cap_kmin : cap_kmin_new;
                    KmaxOut   <= op_err ? cap_kmax : cap_kmax_new;
                    err       <= op_err;
                    empty     <= ~|masked_valid;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wfa_wavefront_compact.sv
// Directed bench for wfa_wavefront_compact: shift/mask vectors, error bounds, timing,
// output hold, input isolation and reset abort.
module tb_wfa_wavefront_compact;

    localparam int N  = 128;
    localparam int W  = 10;
    localparam int DW = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic [N-1:0][W-1:0]  OffsetIn = '0;
    logic [N-1:0]         ValidIn = '0;
    logic signed [DW-1:0] Kmin = '0;
    logic signed [DW-1:0] Kmax = '0;
    logic signed [DW-1:0] KminNew = '0;
    logic signed [DW-1:0] KmaxNew = '0;
    logic [N-1:0][W-1:0]  OffsetOut;
    logic [N-1:0]         ValidOut;
    logic signed [DW-1:0] KminOut;
    logic signed [DW-1:0] KmaxOut;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic                 empty;
    logic [2:0]           fsm_state;

    int vectors = 0;
    int miscompares = 0;

    wfa_wavefront_compact #(
        .MAX_WAVEFRONT_LEN(N),
        .LOG_MAX_TILE_SIZE(W),
        .DATA_WIDTH(DW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .OffsetIn(OffsetIn),
        .ValidIn(ValidIn),
        .Kmin(Kmin),
        .Kmax(Kmax),
        .KminNew(KminNew),
        .KmaxNew(KmaxNew),
        .OffsetOut(OffsetOut),
        .ValidOut(ValidOut),
        .KminOut(KminOut),
        .KmaxOut(KmaxOut),
        .busy(busy),
        .done(done),
        .err(err),
        .empty(empty),
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic set_bounds(input int a, input int b, input int c, input int d);
        Kmin    = DW'(a);
        Kmax    = DW'(b);
        KminNew = DW'(c);
        KmaxNew = DW'(d);
    endtask

    // Pulses start, scrambles all inputs after the sampling edge, then watches 20 edges.
    task automatic run_op(output int done_edge, output int done_cycles,
                          output logic [N-1:0] valid_mid, output int kmin_mid);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        OffsetIn = '1;
        ValidIn  = '1;
        set_bounds(0, 1, 0, 0);
        done_edge = -1;
        done_cycles = 0;
        valid_mid = '0;
        kmin_mid = 0;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk); #1;
            if (e == 8) begin
                valid_mid = ValidOut;
                kmin_mid  = int'(KminOut);
            end
            if (done === 1'b1) begin
                done_cycles++;
                if (done_edge < 0) done_edge = e;
            end
        end
    endtask

    task automatic load_basic();
        OffsetIn = '0;
        for (int j = 0; j < 8; j++) OffsetIn[j] = W'(10 + j);
        ValidIn = 128'hFF;
        set_bounds(-3, 4, -1, 2);
    endtask

    task automatic test_reset();
        #3 rst = 1'b0;
        #1;
        vectors++;
        if ({busy, done, err, empty} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b want 0000", {busy, done, err, empty});
        end
        vectors++;
        if (ValidOut !== '0 || OffsetOut !== '0 || KminOut !== '0 || KmaxOut !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got valid %h kmin %0d kmax %0d want all zero",
                     ValidOut, KminOut, KmaxOut);
        end
        vectors++;
        if (fsm_state !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_state: got %0d want 0", fsm_state);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_shift();
        int de, dc, km;
        logic [N-1:0] vm;
        int exp_off[8];
        int bad;
        exp_off = '{12, 13, 14, 15, 16, 17, 0, 0};
        load_basic();
        run_op(de, dc, vm, km);
        vectors++;
        if (de !== 10 || dc !== 1) begin
            miscompares++;
            $display("FAIL basic_done_timing: got edge %0d cycles %0d want edge 10 cycles 1", de, dc);
        end
        vectors++;
        if (vm !== '0 || km !== 0) begin
            miscompares++;
            $display("FAIL basic_early_update: got valid %h kmin %0d at edge 8 want 0 0", vm, km);
        end
        bad = 0;
        for (int j = 0; j < 8; j++) if (int'(OffsetOut[j]) !== exp_off[j]) bad++;
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL basic_offsets: got %0d %0d %0d %0d %0d want 12 13 14 15 16",
                     OffsetOut[0], OffsetOut[1], OffsetOut[2], OffsetOut[3], OffsetOut[4]);
        end
        vectors++;
        if (ValidOut !== 128'hF) begin
            miscompares++;
            $display("FAIL basic_valid: got %h want f", ValidOut);
        end
        vectors++;
        if (int'(KminOut) !== -1 || int'(KmaxOut) !== 2 || err !== 1'b0 || empty !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_bounds: got kmin %0d kmax %0d err %b empty %b want -1 2 0 0",
                     KminOut, KmaxOut, err, empty);
        end
    endtask

    task automatic test_passthrough();
        int de, dc, km, bad, first;
        logic [N-1:0] vm;
        logic [N-1:0][W-1:0] orig;
        for (int j = 0; j < N; j++) OffsetIn[j] = W'((j * 7 + 3) % 1024);
        orig = OffsetIn;
        ValidIn = 128'hA5;
        set_bounds(-3, 4, -3, 4);
        run_op(de, dc, vm, km);
        vectors++;
        if (vm !== 128'hF || km !== -1) begin
            miscompares++;
            $display("FAIL pass_hold: got valid %h kmin %0d at edge 8 want f -1", vm, km);
        end
        bad = 0;
        first = -1;
        for (int j = 0; j < N; j++) begin
            if (OffsetOut[j] !== orig[j]) begin
                bad++;
                if (first < 0) first = j;
            end
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL pass_offsets: got %0d bad slots, first %0d want 0", bad, first);
        end
        vectors++;
        if (ValidOut !== 128'hA5 || err !== 1'b0 || empty !== 1'b0) begin
            miscompares++;
            $display("FAIL pass_valid: got %h err %b empty %b want a5 0 0", ValidOut, err, empty);
        end
        vectors++;
        if (int'(KminOut) !== -3 || int'(KmaxOut) !== 4 || de !== 10) begin
            miscompares++;
            $display("FAIL pass_bounds: got kmin %0d kmax %0d edge %0d want -3 4 10",
                     KminOut, KmaxOut, de);
        end
    endtask

    task automatic test_far_shift();
        int de, dc, km;
        logic [N-1:0] vm;
        for (int j = 0; j < N; j++) OffsetIn[j] = W'(j);
        OffsetIn[127] = W'(999);
        ValidIn = '1;
        set_bounds(0, 127, 127, 127);
        run_op(de, dc, vm, km);
        vectors++;
        if (ValidOut !== 128'h1 || empty !== 1'b0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL far_valid: got %h empty %b err %b want 1 0 0", ValidOut, empty, err);
        end
        vectors++;
        if (int'(OffsetOut[0]) !== 999 || int'(OffsetOut[1]) !== 0) begin
            miscompares++;
            $display("FAIL far_offsets: got %0d %0d want 999 0", OffsetOut[0], OffsetOut[1]);
        end
        vectors++;
        if (int'(KminOut) !== 127 || int'(KmaxOut) !== 127) begin
            miscompares++;
            $display("FAIL far_bounds: got %0d %0d want 127 127", KminOut, KmaxOut);
        end
    endtask

    task automatic test_mixed_shift();
        int de, dc, km, src, bad, first;
        logic [N-1:0] vm;
        logic [N-1:0] exp_v;
        int exp_o;
        for (int j = 0; j < N; j++) begin
            OffsetIn[j] = W'(j + 100);
            ValidIn[j]  = (j < 31) && (j % 3 != 0);
        end
        set_bounds(-10, 20, -5, 15);
        run_op(de, dc, vm, km);
        bad = 0;
        first = -1;
        exp_v = '0;
        for (int j = 0; j < N; j++) begin
            src = j + 5;
            exp_o = (src < N) ? src + 100 : 0;
            exp_v[j] = (j < 21) && (src < 31) && (src % 3 != 0);
            if (int'(OffsetOut[j]) !== exp_o) begin
                bad++;
                if (first < 0) first = j;
            end
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL mixed_offsets: got %0d bad slots, first %0d want 0", bad, first);
        end
        vectors++;
        if (ValidOut !== exp_v) begin
            miscompares++;
            $display("FAIL mixed_valid: got %h want %h", ValidOut, exp_v);
        end
        vectors++;
        if (int'(KminOut) !== -5 || int'(KmaxOut) !== 15 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL mixed_bounds: got %0d %0d err %b want -5 15 0", KminOut, KmaxOut, err);
        end
    endtask

    task automatic test_errors();
        int de, dc, km;
        logic [N-1:0] vm;
        int t_kmin[3];
        int t_kmax[3];
        int t_kmn[3];
        int t_kmx[3];
        t_kmin = '{-3, 0, 0};
        t_kmax = '{4, 5, 10};
        t_kmn  = '{-4, 1, 5};
        t_kmx  = '{2, 6, 4};
        for (int c = 0; c < 3; c++) begin
            for (int j = 0; j < N; j++) OffsetIn[j] = W'(j + 1);
            ValidIn = '1;
            set_bounds(t_kmin[c], t_kmax[c], t_kmn[c], t_kmx[c]);
            run_op(de, dc, vm, km);
            vectors++;
            if (err !== 1'b1 || ValidOut !== '0 || empty !== 1'b1) begin
                miscompares++;
                $display("FAIL err_case%0d_flags: got err %b valid %h empty %b want 1 0 1",
                         c, err, ValidOut, empty);
            end
            vectors++;
            if (int'(KminOut) !== t_kmin[c] || int'(KmaxOut) !== t_kmax[c] || de !== 10) begin
                miscompares++;
                $display("FAIL err_case%0d_bounds: got %0d %0d edge %0d want %0d %0d 10",
                         c, KminOut, KmaxOut, de, t_kmin[c], t_kmax[c]);
            end
        end
    endtask

    task automatic test_reset_abort();
        int de, dc, km, late_done;
        logic [N-1:0] vm;
        load_basic();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        set_bounds(0, 127, 127, 127);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        vectors++;
        if (fsm_state !== 3'd2 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_restart_ignored: got state %0d busy %b want 2 1", fsm_state, busy);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        vectors++;
        if ({busy, done, err, empty} !== 4'b0000 || fsm_state !== 3'd0) begin
            miscompares++;
            $display("FAIL abort_flags: got %b state %0d want 0000 0", {busy, done, err, empty}, fsm_state);
        end
        vectors++;
        if (OffsetOut !== '0 || ValidOut !== '0 || KminOut !== '0 || KmaxOut !== '0) begin
            miscompares++;
            $display("FAIL abort_data: got valid %h kmin %0d kmax %0d want all zero",
                     ValidOut, KminOut, KmaxOut);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        late_done = 0;
        for (int e = 0; e < 15; e++) begin
            @(posedge clk); #1;
            if (done === 1'b1) late_done++;
        end
        vectors++;
        if (late_done !== 0) begin
            miscompares++;
            $display("FAIL abort_no_done: got %0d done cycles want 0", late_done);
        end
        load_basic();
        run_op(de, dc, vm, km);
        vectors++;
        if (de !== 10 || ValidOut !== 128'hF || int'(OffsetOut[0]) !== 12) begin
            miscompares++;
            $display("FAIL abort_recover: got edge %0d valid %h off0 %0d want 10 f 12",
                     de, ValidOut, OffsetOut[0]);
        end
        vectors++;
        if (int'(KminOut) !== -1 || int'(KmaxOut) !== 2 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_recover_bounds: got %0d %0d err %b want -1 2 0", KminOut, KmaxOut, err);
        end
    endtask

    initial begin
        test_reset();
        test_basic_shift();
        test_passthrough();
        test_far_shift();
        test_mixed_shift();
        test_errors();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wfa_wavefront_compact.md
WFA_WAVEFRONT_COMPACT -- requirements
Module: wfa_wavefront_compact

Interface
REQ-001 SHALL have parameter MAX_WAVEFRONT_LEN, default 128, number of diagonal slots; power of two.
REQ-002 SHALL have parameter LOG_MAX_TILE_SIZE, default 10, width of each offset.
REQ-003 SHALL have parameter DATA_WIDTH, default 8, signed width of diagonal indices.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1; reset is asynchronous and active-low.
REQ-006 SHALL have port start, input, 1, request to compact one wavefront.
REQ-007 SHALL have port OffsetIn, input, MAX_WAVEFRONT_LEN x LOG_MAX_TILE_SIZE, offsets; slot j is diagonal Kmin+j.
REQ-008 SHALL have port ValidIn, input, MAX_WAVEFRONT_LEN x 1, per-slot valid flags.
REQ-009 SHALL have ports Kmin, Kmax, input, DATA_WIDTH signed, current wavefront bounds.
REQ-010 SHALL have ports KminNew, KmaxNew, input, DATA_WIDTH signed, reduced bounds from the wavefront reduction stage.
REQ-011 SHALL have port OffsetOut, output, MAX_WAVEFRONT_LEN x LOG_MAX_TILE_SIZE, compacted offsets; slot j is diagonal KminOut+j.
REQ-012 SHALL have port ValidOut, output, MAX_WAVEFRONT_LEN x 1, compacted valid flags.
REQ-013 SHALL have ports KminOut, KmaxOut, output, DATA_WIDTH signed, bounds of the compacted wavefront.
REQ-014 SHALL have ports busy, done, err and empty, each output, 1 bit.

Function
REQ-015 SHALL implement states IDLE, LOAD, SHIFT, MASK, DONE; busy = 1 in every state except IDLE.
REQ-016 In IDLE, start = 1 SHALL capture OffsetIn, ValidIn, Kmin, Kmax, KminNew and KmaxNew into internal registers; later input changes SHALL have no effect on the current operation.
REQ-017 start SHALL be ignored while busy = 1.
REQ-018 LOAD SHALL compute shift = KminNew - Kmin and numNew = KmaxNew - KminNew + 1 at DATA_WIDTH+1 bits signed.
REQ-019 LOAD SHALL flag an error when shift < 0, KmaxNew > Kmax, or KminNew > KmaxNew.
REQ-020 SHIFT SHALL last exactly log2(MAX_WAVEFRONT_LEN) cycles; in stage s the working array shifts toward slot 0 by 2^s when bit s of shift is 1 and is unchanged otherwise.
REQ-021 Slots vacated by the shift SHALL fill with offset 0 and valid 0.
REQ-022 MASK SHALL clear valid at every slot j >= numNew; offsets SHALL be left unchanged.
REQ-023 On error, MASK SHALL clear all valid flags, set KminOut = Kmin and KmaxOut = Kmax, and set err = 1.
REQ-024 Without error, MASK SHALL set KminOut = KminNew, KmaxOut = KmaxNew, err = 0.
REQ-025 empty SHALL be 1 exactly when no ValidOut bit is set after MASK.
REQ-026 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-027 done SHALL rise at the (log2(MAX_WAVEFRONT_LEN)+3)th rising edge after the edge that sampled start, i.e. the 10th edge for the default parameters.
REQ-028 OffsetOut, ValidOut, KminOut, KmaxOut, err and empty SHALL update only at the edge that leaves MASK, and SHALL hold until the next operation's MASK.
REQ-029 shift = 0 with numNew = Kmax - Kmin + 1 SHALL pass the data through unchanged.

Reset
REQ-030 rst = 0 SHALL immediately force state IDLE and busy, done, err, empty, KminOut, KmaxOut, all OffsetOut and all ValidOut to 0, regardless of clk.
REQ-031 Reset during any non-IDLE state SHALL abort the operation with no done pulse; the first start after rst returns to 1 SHALL run normally.

Verification
REQ-032 Kmin = -3, Kmax = 4, KminNew = -1, KmaxNew = 2, ValidIn[0..7] = 1, OffsetIn[j] = 10+j -> OffsetOut[0..3] = 12..15, ValidOut = 0x0F, KminOut = -1, KmaxOut = 2, done at edge 10.
REQ-033 shift = 0 with identical bounds, ValidIn = 0xA5 -> outputs equal inputs, err = 0, empty = 0.
REQ-034 KminNew = Kmin - 1 -> err = 1, ValidOut all 0, empty = 1, KminOut = Kmin, KmaxOut = Kmax.
REQ-035 Kmin = 0, Kmax = 127, KminNew = KmaxNew = 127, ValidIn[127] = 1 -> only ValidOut[0] = 1, OffsetOut[0] = OffsetIn[127].
REQ-036 Pulse start again at edge 3 of a run, then drop rst to 0 at edge 5 -> the second start is ignored, all outputs are 0 asynchronously, no done pulse follows, and the next start completes normally.
